tis_exec_ctrl: RTL

Execution sequencer for a single TIS node core. It streams a program into the core's instruction store and publishes the program length. It then gates the core with a one-cycle clock-enable to provide free-run at a divided rate, single-step, halt and PC breakpoint. It sits between board controls (buttons/switches, or a host loader) and core/prog, replacing the raw button-clock drive of the core.

---
 rtl/tis_pkg.sv | 18 +
 rtl/tis_tick_div.sv | 31 +++
 rtl/tis_exec_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/tis_pkg.sv
// Shared definitions for the TIS node execution controller.
//   PC_W    : pc / instruction-store address / program length width
//   INSTR_W : instruction word width
//   ctrl_state_e : sequencer state, published on the controller's state port
package tis_pkg;

  localparam int unsigned PC_W    = 4;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    HALT = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/tis_tick_div.sv
// Run-rate divider: counts 0..rate_div and raises tick on the terminal count.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : hold the counter at zero (asserted whenever not free-running)
//   rate_div   : terminal count; one tick per rate_div+1 cycles
//   tick       : terminal count reached this cycle
module tis_tick_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] rate_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = !clr && (cnt == rate_div);

  // Wrap on >= so a rate_div lowered mid-count recovers immediately
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (cnt >= rate_div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tis_exec_ctrl.sv
// Execution sequencer for one TIS node core: streams a program into the
// instruction store, then gates the core with a one-cycle enable for
// free-run (divided rate), single-step, halt and pc breakpoint.
//   load_valid/ready/data/last : program word stream
//   run_req, step_req, halt_req: run level, step (edge), forced halt
//   bp_en, bp_pc               : breakpoint control
//   rate_div                   : one core_en per rate_div+1 cycles in RUN
//   core_pc                    : current core pc (breakpoint compare)
//   core_en, core_rst          : core advance strobe / core reset
//   prog_we/waddr/wdata        : instruction store write port
//   p_length, state, cycles, load_err : status
module tis_exec_ctrl
  import tis_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 15,
  parameter int unsigned INSTR_W    = tis_pkg::INSTR_W,
  parameter int unsigned PC_W       = tis_pkg::PC_W,
  parameter int unsigned CYC_W      = 16,
  parameter int unsigned DIV_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               halt_req,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_pc,
  input  logic [DIV_W-1:0]   rate_div,
  input  logic [PC_W-1:0]    core_pc,
  output logic               core_en,
  output logic               core_rst,
  output logic               prog_we,
  output logic [PC_W-1:0]    prog_waddr,
  output logic [INSTR_W-1:0] prog_wdata,
  output logic [PC_W-1:0]    p_length,
  output logic [2:0]         state,
  output logic [CYC_W-1:0]   cycles,
  output logic               load_err
);

  localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(PROG_DEPTH - 1);
  localparam logic [PC_W-1:0] FULL_LEN  = PC_W'(PROG_DEPTH);

  ctrl_state_e st, st_n;

  logic [PC_W-1:0] count;
  logic            step_q;
  logic            resume;
  logic            tick;
  logic            step_edge;
  logic            have_prog;

  logic start_load, start_run, word_acc, load_fin, load_full, clr_resume;

  assign step_edge  = step_req & ~step_q;
  assign have_prog  = (p_length != '0);
  assign prog_waddr = count;
  assign prog_wdata = load_data;
  assign core_rst   = (st == IDLE) || (st == LOAD);
  assign state      = st;

  tis_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (st != RUN),
    .rate_div (rate_div),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
    end else begin
      st <= st_n;
    end
  end

  always_comb begin
    st_n       = st;
    core_en    = 1'b0;
    load_ready = 1'b0;
    prog_we    = 1'b0;
    start_load = 1'b0;
    start_run  = 1'b0;
    word_acc   = 1'b0;
    load_fin   = 1'b0;
    load_full  = 1'b0;
    clr_resume = 1'b0;
    case (st)
      IDLE, HALT: begin
        if (load_valid) begin
          st_n       = LOAD;
          start_load = 1'b1;
        end else if (have_prog && step_edge && !halt_req) begin
          st_n = STEP;
        end else if (have_prog && run_req && !halt_req) begin
          st_n      = RUN;
          start_run = 1'b1;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          prog_we  = 1'b1;
          word_acc = 1'b1;
          if (load_last) begin
            load_fin = 1'b1;
            st_n     = IDLE;
          end else if (count == LAST_ADDR) begin
            load_full = 1'b1;
            st_n      = IDLE;
          end
        end
      end
      RUN: begin
        // A halt request outranks a coinciding tick
        if (halt_req || !run_req) begin
          st_n = HALT;
        end else if (tick) begin
          // resume lets the first tick after (re)starting pass the breakpoint
          if (bp_en && (core_pc == bp_pc) && !resume) begin
            st_n = HALT;
          end else begin
            core_en    = 1'b1;
            clr_resume = 1'b1;
          end
        end
      end
      STEP: begin
        core_en = 1'b1;
        st_n    = HALT;
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      p_length <= '0;
      cycles   <= '0;
      load_err <= 1'b0;
      step_q   <= 1'b0;
      resume   <= 1'b0;
    end else begin
      step_q <= step_req;
      if (start_load) begin
        count    <= '0;
        cycles   <= '0;
        load_err <= 1'b0;
      end else if (word_acc) begin
        count <= count + 1'b1;
      end
      if (load_fin) begin
        p_length <= count + 1'b1;
      end
      if (load_full) begin
        p_length <= FULL_LEN;
        load_err <= 1'b1;
      end
      if (start_run) begin
        resume <= 1'b1;
      end else if (clr_resume) begin
        resume <= 1'b0;
      end
      if (core_en && (cycles != '1)) begin
        cycles <= cycles + 1'b1;
      end
    end
  end

endmodule
